pulse_spacer: RTL

Fast-domain event pacer placed directly upstream of the fast-to-slow toggle pulse synchronizer. Accepts event requests at up to one per clock, counts them in a saturating pending counter, and re-issues them as single-cycle pulses spaced at least GAP clocks apart. Each emitted pulse therefore arrives as a separate toggle the slow domain can resolve, instead of two toggles cancelling. Flags dropped events when the pending counter is full.

---
 rtl/pulse_spacer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pulse_spacer.sv
// Paces event requests into single-cycle pulses spaced GAP clocks apart, with a saturating backlog.
// Define PULSE_SPACER_STICKY_OVF_EN for a sticky overflow flag cleared by ovf_clr.
module pulse_spacer #(
    parameter int unsigned GAP   = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             evt_in,
    input  logic             ovf_clr,
    output logic             pulse_out,
    output logic [CNT_W-1:0] pending,
    output logic             busy,
    output logic             overflow
);

    localparam int unsigned GAP_W = 8;
    localparam logic [CNT_W-1:0] PEND_MAX = '1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;
    logic             dec;
    logic             drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gap_cnt_q <= '0;
            pending_q <= '0;
            pulse_q   <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            pending_q <= pending_d;
            pulse_q   <= pulse_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
        end
    end

    // Next state; a backlog at the end of the gap goes straight back to EMIT.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        dec       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pending_q != '0) begin
                    state_d = ST_EMIT;
                    dec     = 1'b1;
                end
            end
            ST_EMIT: begin
                state_d   = ST_GAP;
                gap_cnt_d = GAP_LOAD;
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    if (pending_q != '0) begin
                        state_d = ST_EMIT;
                        dec     = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Saturating backlog; an emit in the same cycle makes room for an event at full.
    always_comb begin
        pending_d = pending_q;
        drop      = evt_in && !dec && (pending_q == PEND_MAX);
        if (evt_in && !dec && !drop) begin
            pending_d = pending_q + CNT_W'(1);
        end else if (dec && !evt_in) begin
            pending_d = pending_q - CNT_W'(1);
        end
    end

    always_comb begin
        pulse_d = (state_d == ST_EMIT);
        busy_d  = (state_d != ST_IDLE) || (pending_d != '0);
    end

`ifdef PULSE_SPACER_STICKY_OVF_EN
    // Set has priority over clear.
    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;

    always_comb begin
        ovf_d = drop;
    end
`endif

    assign pulse_out = pulse_q;
    assign pending   = pending_q;
    assign busy      = busy_q;
    assign overflow  = ovf_q;

endmodule
